// File: rtl/ftrace_pkg.sv
// Shared constants and event type for the function-trace return-address stack.
package ftrace_pkg;

   localparam logic [6:0]  OP_JAL   = 7'b1101111;
   localparam logic [6:0]  OP_JALR  = 7'b1100111;
   localparam logic [31:0] RET_INSN = 32'h0000_8067;
   localparam logic [4:0]  RA_REG   = 5'd1;

   typedef enum logic {
      EVT_CALL = 1'b0,
      EVT_RET  = 1'b1
   } evt_kind_e;

endpackage

// File: rtl/ftrace_ras_mem.sv
// Return-address storage: one write port, combinational top-of-stack read.
module ftrace_ras_mem #(
   parameter int DEPTH = 16,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [XLEN-1:0]          wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [XLEN-1:0]          rdata
);

   logic [XLEN-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/ftrace_ras.sv
// Shadow return-address stack that classifies retired calls/returns and flags stack anomalies.
// Build option: define FTRACE_RAS_CIRC_EN to let a full-stack push overwrite the oldest entry.
module ftrace_ras
   import ftrace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     retire_valid,
   input  logic [31:0]              ist,
   input  logic [XLEN-1:0]          pc,
   input  logic [XLEN-1:0]          pc_next,
   output logic                     evt_valid,
   output logic                     evt_is_ret,
   output logic [XLEN-1:0]          evt_target,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     mismatch,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]   sp;
   logic            is_call;
   logic            is_ret;
   logic            full;
   logic            empty;
   logic            push_en;
   logic [XLEN-1:0] top;
   evt_kind_e       kind;

   always_comb begin
      is_call = 1'b0;
      is_ret  = 1'b0;
      if (retire_valid) begin
         is_call = (ist[11:7] == RA_REG) &&
                   ((ist[6:0] == OP_JAL) ||
                    ((ist[6:0] == OP_JALR) && (ist[14:12] == 3'b000)));
         is_ret  = !is_call && (ist == RET_INSN);
      end
   end

   assign kind  = is_call ? EVT_CALL : EVT_RET;
   assign full  = (depth == (AW+1)'(DEPTH));
   assign empty = (depth == '0);

`ifdef FTRACE_RAS_CIRC_EN
   assign push_en = is_call;
`else
   assign push_en = is_call && !full;
`endif

   // sp points at the next free slot; when full in circular mode it lands on the oldest entry
   ftrace_ras_mem #(.DEPTH(DEPTH), .XLEN(XLEN)) u_mem (
      .clk   (clk),
      .we    (push_en),
      .waddr (sp),
      .wdata (pc + XLEN'(4)),
      .raddr (sp - AW'(1)),
      .rdata (top)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sp         <= '0;
         depth      <= '0;
         evt_valid  <= 1'b0;
         evt_is_ret <= 1'b0;
         evt_target <= '0;
         mismatch   <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         evt_valid <= is_call || is_ret;
         if (is_call || is_ret) begin
            evt_is_ret <= (kind == EVT_RET);
            evt_target <= pc_next;
         end
         if (push_en) sp <= sp + AW'(1);
         if (is_call) begin
            if (full) overflow <= 1'b1;
            else      depth    <= depth + 1'b1;
         end
         if (is_ret) begin
            if (empty) begin
               underflow <= 1'b1;
            end else begin
               sp    <= sp - AW'(1);
               depth <= depth - 1'b1;
               if (top != pc_next) mismatch <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ftrace_ras.sv
// Directed scoreboard bench for ftrace_ras (DEPTH=16, XLEN=32); honours FTRACE_RAS_CIRC_EN.
module tb_ftrace_ras;

   localparam logic [31:0] JAL_RA   = 32'h1000_00EF;
   localparam logic [31:0] JALR_RA  = 32'h0000_80E7;
   localparam logic [31:0] RET      = 32'h0000_8067;
   localparam logic [31:0] JAL_X0   = 32'h0000_006F;
   localparam logic [31:0] JALR_F3  = 32'h0000_90E7;
   localparam logic [31:0] ADDI     = 32'h0000_0013;
   localparam int K_OTHER = 0, K_CALL = 1, K_RET = 2;

   typedef struct packed {
      logic        ev;
      logic        ir;
      logic [31:0] tgt;
      logic [4:0]  dep;
      logic        mm;
      logic        ov;
      logic        un;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        retire_valid = 1'b0;
   logic [31:0] ist = '0;
   logic [31:0] pc = '0;
   logic [31:0] pc_next = '0;
   logic        evt_valid, evt_is_ret, mismatch, overflow, underflow;
   logic [31:0] evt_target;
   logic [4:0]  depth;

   int total = 0;
   int bad = 0;

   logic [31:0] mstk[$];
   logic        m_mm, m_ov, m_un;
   exp_t        scb[$];

   ftrace_ras #(.DEPTH(16), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .ist(ist),
      .pc(pc), .pc_next(pc_next), .evt_valid(evt_valid), .evt_is_ret(evt_is_ret),
      .evt_target(evt_target), .depth(depth), .mismatch(mismatch),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (scb.size() == 0) begin
         chk("scb_empty", 32'd1, 32'd0);
         return;
      end
      e = scb.pop_front();
      chk("evt_valid", {31'd0, evt_valid}, {31'd0, e.ev});
      if (e.ev) begin
         chk("evt_is_ret", {31'd0, evt_is_ret}, {31'd0, e.ir});
         chk("evt_target", evt_target, e.tgt);
      end
      chk("depth", {27'd0, depth}, {27'd0, e.dep});
      chk("mismatch", {31'd0, mismatch}, {31'd0, e.mm});
      chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
      chk("underflow", {31'd0, underflow}, {31'd0, e.un});
   endtask

   // called at a negedge: drive one retire, predict, then check after the next posedge
   task automatic retire(input logic v, input logic [31:0] insn, input logic [31:0] p,
                         input logic [31:0] pn, input int kind);
      exp_t e;
      logic [31:0] popped;
      rst_n = 1'b1;
      retire_valid = v;
      ist = insn;
      pc = p;
      pc_next = pn;
      e = '0;
      if (v && kind == K_CALL) begin
         e.ev = 1'b1; e.ir = 1'b0; e.tgt = pn;
         if (mstk.size() == 16) begin
            m_ov = 1'b1;
`ifdef FTRACE_RAS_CIRC_EN
            void'(mstk.pop_front());
            mstk.push_back(p + 32'd4);
`endif
         end else begin
            mstk.push_back(p + 32'd4);
         end
      end else if (v && kind == K_RET) begin
         e.ev = 1'b1; e.ir = 1'b1; e.tgt = pn;
         if (mstk.size() == 0) m_un = 1'b1;
         else begin
            popped = mstk.pop_back();
            if (popped != pn) m_mm = 1'b1;
         end
      end
      e.dep = 5'(mstk.size());
      e.mm = m_mm; e.ov = m_ov; e.un = m_un;
      scb.push_back(e);
      @(negedge clk);
      check_out();
   endtask

   // reset asserted alongside a call that must be discarded
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      retire_valid = 1'b1;
      ist = JAL_RA;
      pc = 32'h0000_4000;
      pc_next = 32'h0000_5000;
      @(negedge clk);
      chk({tag, "_evt_valid"}, {31'd0, evt_valid}, 32'd0);
      chk({tag, "_evt_is_ret"}, {31'd0, evt_is_ret}, 32'd0);
      chk({tag, "_evt_target"}, evt_target, 32'd0);
      chk({tag, "_depth"}, {27'd0, depth}, 32'd0);
      chk({tag, "_flags"}, {29'd0, mismatch, overflow, underflow}, 32'd0);
      mstk.delete();
      scb.delete();
      m_mm = 1'b0; m_ov = 1'b0; m_un = 1'b0;
      rst_n = 1'b1;
      retire_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] t;
      m_mm = 1'b0; m_ov = 1'b0; m_un = 1'b0;
      @(negedge clk);
      do_reset("rst0");

      // basic call / matching return / mismatching return
      retire(1'b1, JAL_RA, 32'h8000_0000, 32'h8000_0100, K_CALL);
      retire(1'b1, RET,    32'h8000_0100, 32'h8000_0004, K_RET);
      retire(1'b1, JAL_RA, 32'h8000_0000, 32'h8000_0100, K_CALL);
      retire(1'b1, RET,    32'h8000_0100, 32'h8000_0008, K_RET);
      retire(1'b0, ADDI,   32'h8000_0008, 32'h8000_000C, K_OTHER);
      chk("mm_sticky", {31'd0, mismatch}, 32'd1);

      // return on empty stack
      retire(1'b1, RET, 32'h8000_000C, 32'h8000_0010, K_RET);
      chk("underflow_set", {31'd0, underflow}, 32'd1);

      // jalr x1 is a call; lookalikes and idle cycles are not
      retire(1'b1, JALR_RA, 32'h0000_2000, 32'h0000_3000, K_CALL);
      retire(1'b1, JAL_X0,  32'h0000_3000, 32'h0000_3100, K_OTHER);
      retire(1'b1, JALR_F3, 32'h0000_3100, 32'h0000_3200, K_OTHER);
      retire(1'b1, ADDI,    32'h0000_3200, 32'h0000_3204, K_OTHER);
      retire(1'b0, JAL_RA,  32'h0000_3204, 32'h0000_3300, K_OTHER);
      retire(1'b1, JAL_RA,  32'hFFFF_FFFC, 32'h0000_0040, K_CALL);
      retire(1'b1, RET,     32'h0000_0040, 32'h0000_0000, K_RET);

      do_reset("rst_mid");
      retire(1'b1, RET, 32'h0000_6000, 32'h0000_6004, K_RET);

      // fill past capacity then unwind
      do_reset("rst_ovf");
      for (int i = 0; i < 17; i++)
         retire(1'b1, JAL_RA, 32'h1000 + 32'(i) * 32'h10, 32'h0000_9000, K_CALL);
      chk("overflow_set", {31'd0, overflow}, 32'd1);
      chk("depth_full", {27'd0, depth}, 32'd16);
      for (int k = 0; k < 16; k++) begin
`ifdef FTRACE_RAS_CIRC_EN
         t = 32'h1104 - 32'(k) * 32'h10;
`else
         t = 32'h10F4 - 32'(k) * 32'h10;
`endif
         retire(1'b1, RET, 32'h0000_9000, t, K_RET);
      end
      chk("unwind_mm", {31'd0, mismatch}, 32'd0);
      chk("unwind_depth", {27'd0, depth}, 32'd0);
      retire(1'b1, RET, 32'h0000_9000, 32'h0000_1004, K_RET);
      chk("unwind_underflow", {31'd0, underflow}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ftrace_ras.md
FTRACE_RAS -- requirements
Module: ftrace_ras

Interface
REQ-001 Parameter DEPTH, default 16, shadow return-address stack entries (power of two, 4..64).
REQ-002 Parameter XLEN, default 32, address width.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-005 retire_valid  input  1  one instruction retires this cycle.
REQ-006 ist  input  32  retired instruction word.
REQ-007 pc  input  XLEN  PC of retired instruction.
REQ-008 pc_next  input  XLEN  next PC after retired instruction.
REQ-009 evt_valid  output  1  registered event strobe, one cycle per classified call/ret.
REQ-010 evt_is_ret  output  1  0 = call, 1 = return; qualified by evt_valid.
REQ-011 evt_target  output  XLEN  call target (pc_next) or return target (pc_next).
REQ-012 depth  output  $clog2(DEPTH)+1  current stack occupancy.
REQ-013 mismatch  output  1  sticky: a return target differed from the popped address.
REQ-014 overflow  output  1  sticky: push attempted with depth == DEPTH.
REQ-015 underflow  output  1  sticky: pop attempted with depth == 0.

Function
REQ-016 Call = retire_valid and (ist[6:0]==1101111 with rd==1, or ist[6:0]==1100111, funct3==000, rd==1).
REQ-017 Return = retire_valid and ist == 0x00008067.
REQ-018 Call has priority; an instruction that satisfies both rules is treated as a call only.
REQ-019 Call: push pc+4 (XLEN wrap-around on addition), depth+1, next cycle evt_valid=1, evt_is_ret=0, evt_target=pc_next.
REQ-020 Return with depth>0: pop top, depth-1; if popped value != pc_next, set mismatch next cycle; evt_valid=1, evt_is_ret=1, evt_target=pc_next.
REQ-021 Return with depth==0: no pop, depth stays 0, set underflow; evt still emitted, mismatch unchanged.
REQ-022 Latency: event outputs and flags updated exactly one cycle after the qualifying retire cycle; depth updates same edge.
REQ-023 Non-call/non-return retire or retire_valid=0: no state change, evt_valid=0 next cycle.
REQ-024 Back-to-back call/ret on consecutive cycles fully supported; return in cycle N+1 sees push from cycle N.
REQ-025 Sticky flags clear only on reset.

Reset
REQ-026 rst_n low at clock edge: depth=0, stack pointer=0, evt_valid=0, evt_is_ret=0, evt_target=0, mismatch=0, overflow=0, underflow=0.
REQ-027 Reset in the same cycle as a retire discards that retire; stack contents need not be cleared.

Configuration
REQ-028 Macro FTRACE_RAS_CIRC_EN defined: push at depth==DEPTH overwrites oldest entry (circular), depth stays DEPTH, overflow set.
REQ-029 Macro FTRACE_RAS_CIRC_EN undefined: push at depth==DEPTH is dropped, stack unchanged, depth stays DEPTH, overflow set.
REQ-030 In both builds the call event is still emitted on overflow.

Structure
REQ-031 Shared package ftrace_pkg holds opcode constants (OP_JAL, OP_JALR), RET_INSN=0x00008067, RA_REG=1 and the call/ret event type.
REQ-032 Storage in sub-module ftrace_ras_mem (DEPTH x XLEN register array, one write port, one combinational read port at top-of-stack); classification and control stay in ftrace_ras.

Verification
REQ-033 Reset, then jal ra at pc=0x80000000 to 0x80000100 -> next cycle evt_valid=1, evt_is_ret=0, evt_target=0x80000100, depth=1.
REQ-034 Following ret with pc_next=0x80000004 -> evt_is_ret=1, depth=0, mismatch=0; repeat with pc_next=0x80000008 -> mismatch=1 and stays 1.
REQ-035 ret with depth=0 -> underflow=1, depth=0, evt_valid=1.
REQ-036 DEPTH=16, 17 calls pc=0x1000+0x10*i: no-CIRC build -> overflow=1, 16 rets return 0x10F4 down to 0x1004; CIRC build -> 16 rets return 0x1104 down to 0x1014.
REQ-037 jalr x1,0(x1) (0x000080E7) -> classified as call, depth+1; rst_n low for one cycle mid-sequence -> all outputs zero, subsequent ret flags underflow.
